// File: rtl/aes_enc_pipe.sv
// AES-128/192/256 encryption pipeline with one round per register stage.
// Backpressure stalls the whole pipeline at once. Each block carries a user
// tag through the pipeline, and a counter records completed output handshakes.

package aes_enc_pkg;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes followed by ShiftRows; byte k sits at bits [127-8k -: 8], row k%4, column k/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    int src;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      src = (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
      r[127-8*k -: 8] = sbox(s[127-8*src -: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction
endpackage

module add_round_key (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  assign state_o = state_i ^ key_i;
endmodule

module encrypt_round (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  assign state_o = aes_enc_pkg::mix_cols(aes_enc_pkg::sub_shift(state_i)) ^ key_i;
endmodule

module encrypt_final_round (
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);
  assign state_o = aes_enc_pkg::sub_shift(state_i) ^ key_i;
endmodule

module aes_enc_pipe #(
  parameter int  KEY_BITS = 128,
  parameter int  TAG_W    = 8,
  parameter int  CNT_W    = 32,
  localparam int NR       = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(NR+1)*128-1:0] round_keys,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  busy,
  output logic [CNT_W-1:0]      blk_count
);

  if (!(KEY_BITS inside {128, 192, 256})) begin : g_bad_key
    $error("aes_enc_pipe: KEY_BITS must be 128, 192 or 256");
  end
  if (TAG_W < 1 || CNT_W < 1) begin : g_bad_width
    $error("aes_enc_pipe: TAG_W and CNT_W must be at least 1");
  end

  logic                   en;
  logic                   out_hs;
  logic [127:0]           whitened;
  logic [NR:1][127:0]     stg_in, st_d, st_q;
  logic [NR:1][TAG_W-1:0] tag_q;
  logic [NR:1]            vld_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;

  // A single enable moves every stage together. The pipeline stalls only
  // when a finished block is waiting at the output. Bubbles ahead of the
  // output stage therefore still fill while out_ready is low.
  assign en        = !(vld_q[NR] && !out_ready);
  assign in_ready  = en;
  assign out_hs    = vld_q[NR] && out_ready;
  assign out_valid = vld_q[NR];
  assign out_data  = st_q[NR];
  assign out_tag   = tag_q[NR];
  assign busy      = |vld_q;
  assign blk_count = cnt_q;

  add_round_key u_ark (.state_i(in_data), .key_i(round_keys[127:0]), .state_o(whitened));

  for (genvar s = 1; s <= NR; s++) begin : g_stage
    if (s == 1) begin : g_first
      assign stg_in[s] = whitened;
    end else begin : g_next
      assign stg_in[s] = st_q[s-1];
    end
    if (s < NR) begin : g_rnd
      encrypt_round u_rnd (.state_i(stg_in[s]), .key_i(round_keys[128*s +: 128]), .state_o(st_d[s]));
    end else begin : g_fin
      encrypt_final_round u_fin (.state_i(stg_in[s]), .key_i(round_keys[128*s +: 128]), .state_o(st_d[s]));
    end
  end

  // Counter of completed output handshakes; wraps naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) cnt_d = cnt_q + CNT_W'(1);
  end

  // Stage registers: state, tag and valid shift together on en, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      tag_q <= '0;
      vld_q <= '0;
    end else if (en) begin
      st_q  <= st_d;
      tag_q <= {tag_q[NR-1:1], in_tag};
      vld_q <= {vld_q[NR-1:1], in_valid};
    end
  end

  // Block counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_aes_enc_pipe.sv
// Directed bench for aes_enc_pipe: FIPS-197 known answers for all three key
// sizes, back-to-back streaming, random stalls, counter wrap and async reset.
module tb_aes_enc_pipe;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] K256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk, rst_n, in_valid, out_ready;
  logic [127:0] in_data;
  logic [7:0] in_tag;
  logic [1919:0] rk_a, rk_b, rk_c;

  logic a_in_ready, a_out_valid, a_busy; logic [127:0] a_out_data; logic [7:0] a_out_tag; logic [31:0] a_blk_count;
  logic b_in_ready, b_out_valid, b_busy; logic [127:0] b_out_data; logic [7:0] b_out_tag; logic [31:0] b_blk_count;
  logic c_in_ready, c_out_valid, c_busy; logic [127:0] c_out_data; logic [7:0] c_out_tag; logic [31:0] c_blk_count;
  logic d_in_ready, d_out_valid, d_busy; logic [127:0] d_out_data; logic [7:0] d_out_tag; logic [3:0]  d_blk_count;

  int n_chk = 0, n_fail = 0, n_out = 0;
  logic [7:0] sb [256];
  logic [135:0] exp_q [$];
  logic hold_vld = 1'b0;
  logic [127:0] hold_d;
  logic [7:0] hold_t;

  aes_enc_pipe #(.KEY_BITS(128), .TAG_W(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .round_keys(rk_a[1407:0]), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_tag(a_out_tag), .busy(a_busy), .blk_count(a_blk_count));
  aes_enc_pipe #(.KEY_BITS(192), .TAG_W(8), .CNT_W(32)) u_d192 (
    .clk(clk), .rst_n(rst_n), .round_keys(rk_b[1663:0]), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_tag(b_out_tag), .busy(b_busy), .blk_count(b_blk_count));
  aes_enc_pipe #(.KEY_BITS(256), .TAG_W(8), .CNT_W(32)) u_d256 (
    .clk(clk), .rst_n(rst_n), .round_keys(rk_c[1919:0]), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_tag(c_out_tag), .busy(c_busy), .blk_count(c_blk_count));
  aes_enc_pipe #(.KEY_BITS(128), .TAG_W(8), .CNT_W(4)) u_dw4 (
    .clk(clk), .rst_n(rst_n), .round_keys(rk_a[1407:0]), .in_valid(in_valid), .in_ready(d_in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_data(d_out_data), .out_tag(d_out_tag), .busy(d_busy), .blk_count(d_blk_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) multiply; the reference S-box comes from field inversion + affine map
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] a);
    logic [7:0] x;
    x = 8'h01;
    for (int i = 0; i < 254; i++) x = gm(x, a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key schedule for key bytes 00,01,02,... of nk 32-bit words
  function automatic logic [1919:0] expand(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1919:0] r;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    r = '0;
    for (int q = 0; q < 4*(nr+1); q++) r[128*(q/4) + 32*(3 - q%4) +: 32] = w[q];
    return r;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [1919:0] rk, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++) s[row+4*col] = t[row + 4*((col+row)%4)];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[128*r + 127 - 8*k -: 8];
    end
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
    return o;
  endfunction

  // One clock cycle on the 128-bit DUT: drive at negedge, check, scoreboard, advance
  task automatic cycle(input logic iv, input logic [127:0] d, input logic [7:0] t,
                       input logic ordy, output logic acc);
    logic [135:0] e;
    in_valid = iv; in_data = d; in_tag = t; out_ready = ordy;
    #1;
    n_chk++;
    if (a_in_ready !== !(a_out_valid && !ordy)) begin
      n_fail++; $display("FAIL in_ready_rule: got %b with out_valid=%b out_ready=%b", a_in_ready, a_out_valid, ordy);
    end
    if (hold_vld) begin
      n_chk++;
      if (a_out_valid !== 1'b1 || a_out_data !== hold_d || a_out_tag !== hold_t) begin
        n_fail++; $display("FAIL stall_hold: got v=%b %h/%h want 1 %h/%h", a_out_valid, a_out_data, a_out_tag, hold_d, hold_t);
      end
    end
    acc = iv && a_in_ready;
    if (a_out_valid && ordy) begin
      n_out++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL spurious_out: got %h/%h want no output", a_out_data, a_out_tag);
      end else begin
        e = exp_q.pop_front();
        if ({a_out_data, a_out_tag} !== e) begin
          n_fail++; $display("FAIL stream_data: got %h/%h want %h/%h", a_out_data, a_out_tag, e[135:8], e[7:0]);
        end
      end
    end
    hold_vld = a_out_valid && !ordy;
    hold_d = a_out_data; hold_t = a_out_tag;
    if (acc) exp_q.push_back({ref_enc(d, rk_a, 10), t});
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({a_out_valid, a_busy, b_out_valid, b_busy, c_out_valid, c_busy, d_out_valid, d_busy} !== 8'h00) begin
      n_fail++; $display("FAIL rst_valid_busy: got %b want 00000000", {a_out_valid, a_busy, b_out_valid, b_busy, c_out_valid, c_busy, d_out_valid, d_busy});
    end
    n_chk++;
    if ({a_out_data, b_out_data, c_out_data, d_out_data} !== '0 || {a_out_tag, b_out_tag, c_out_tag, d_out_tag} !== '0) begin
      n_fail++; $display("FAIL rst_data_tag: got %h %h want 0", a_out_data, a_out_tag);
    end
    n_chk++;
    if (a_blk_count !== 32'd0 || b_blk_count !== 32'd0 || c_blk_count !== 32'd0 || d_blk_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_count: got %0d %0d %0d %0d want 0", a_blk_count, b_blk_count, c_blk_count, d_blk_count);
    end
    n_chk++;
    if ({a_in_ready, b_in_ready, c_in_ready, d_in_ready} !== 4'hf) begin
      n_fail++; $display("FAIL rst_in_ready: got %b want 1111", {a_in_ready, b_in_ready, c_in_ready, d_in_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_blk_count !== 32'd0) begin
      n_fail++; $display("FAIL post_rst: got v=%b rdy=%b cnt=%0d want 0 1 0", a_out_valid, a_in_ready, a_blk_count);
    end
  endtask

  task automatic test_kat;
    in_valid = 1'b1; in_data = PT; in_tag = 8'h5a; out_ready = 1'b1;
    #1;
    n_chk++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL kat_accept: got %b want 1", a_in_ready); end
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_tag = '0;
    for (int e = 1; e <= 15; e++) begin
      n_chk++;
      if (a_out_valid !== (e == 10) || b_out_valid !== (e == 12) || c_out_valid !== (e == 14)) begin
        n_fail++; $display("FAIL kat_latency: edge %0d got %b%b%b want %b%b%b", e, a_out_valid, b_out_valid, c_out_valid, e == 10, e == 12, e == 14);
      end
      if (e == 10) begin
        n_chk++;
        if (a_out_data !== K128 || a_out_tag !== 8'h5a || a_blk_count !== 32'd0) begin
          n_fail++; $display("FAIL kat128: got %h/%h cnt %0d want %h/5a cnt 0", a_out_data, a_out_tag, a_blk_count, K128);
        end
      end
      if (e == 11) begin
        n_chk++;
        if (a_blk_count !== 32'd1) begin n_fail++; $display("FAIL kat128_count: got %0d want 1", a_blk_count); end
      end
      if (e == 12) begin
        n_chk++;
        if (b_out_data !== K192 || b_out_tag !== 8'h5a) begin
          n_fail++; $display("FAIL kat192: got %h/%h want %h/5a", b_out_data, b_out_tag, K192);
        end
      end
      if (e == 14) begin
        n_chk++;
        if (c_out_data !== K256 || c_out_tag !== 8'h5a) begin
          n_fail++; $display("FAIL kat256: got %h/%h want %h/5a", c_out_data, c_out_tag, K256);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (b_blk_count !== 32'd1 || c_blk_count !== 32'd1) begin
      n_fail++; $display("FAIL kat_counts: got %0d %0d want 1 1", b_blk_count, c_blk_count);
    end
  endtask

  task automatic test_back_to_back;
    logic acc;
    int n0, want;
    n0 = n_out;
    for (int i = 0; i < 110; i++) begin
      if (i < 100) cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 8'(i), 1'b1, acc);
      else         cycle(1'b0, '0, '0, 1'b1, acc);
      want = (i < 10) ? 0 : i - 9;
      n_chk++;
      if (n_out - n0 != want) begin
        n_fail++; $display("FAIL b2b_rate: cycle %0d got %0d outputs want %0d", i, n_out - n0, want);
      end
    end
    n_chk++;
    if (a_blk_count !== 32'd101 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: got %0d left %0d want 101 left 0", a_blk_count, exp_q.size());
    end
  endtask

  task automatic test_stall;
    logic acc;
    logic [127:0] pd;
    logic [7:0] tg;
    int sent, guard;
    sent = 0; guard = 0; tg = 8'h80;
    pd = {$urandom, $urandom, $urandom, $urandom};
    while (sent < 60 && guard < 2000) begin
      cycle($urandom_range(0, 2) != 0, pd, tg, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        sent++; tg++;
        pd = {$urandom, $urandom, $urandom, $urandom};
      end
      guard++;
    end
    n_chk++;
    if (sent != 60) begin n_fail++; $display("FAIL stall_timeout: got %0d blocks sent want 60", sent); end
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, '0, 1'b1, acc);
    n_chk++;
    if (a_blk_count !== 32'd161 || exp_q.size() != 0 || a_busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got cnt %0d left %0d busy %b want 161 0 0", a_blk_count, exp_q.size(), a_busy);
    end
  endtask

  task automatic test_reset_midflight;
    logic acc;
    for (int i = 0; i < 5; i++) cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 8'(8'hc0 + i), 1'b0, acc);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, acc);
    n_chk++;
    if (a_out_valid !== 1'b1 || a_busy !== 1'b1 || a_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL pre_rst_stall: got v=%b busy=%b rdy=%b want 1 1 0", a_out_valid, a_busy, a_in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_blk_count !== 32'd0 || d_blk_count !== 4'd0) begin
      n_fail++; $display("FAIL async_rst: got v=%b busy=%b cnt=%0d want 0 0 0", a_out_valid, a_busy, a_blk_count);
    end
    n_chk++;
    if (a_out_data !== '0 || a_out_tag !== '0 || a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_rst_data: got %h/%h rdy=%b want 0/0 1", a_out_data, a_out_tag, a_in_ready);
    end
    exp_q.delete();
    hold_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = PT; in_tag = 8'h3c; out_ready = 1'b1;
    #1;
    n_chk++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready: got %b want 1", a_in_ready); end
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; in_tag = '0;
    for (int e = 1; e <= 14; e++) begin
      n_chk++;
      if (a_out_valid !== (e == 10)) begin
        n_fail++; $display("FAIL rel_latency: edge %0d got %b want %b", e, a_out_valid, e == 10);
      end
      if (e == 10) begin
        n_chk++;
        if (a_out_data !== K128 || a_out_tag !== 8'h3c) begin
          n_fail++; $display("FAIL rel_data: got %h/%h want %h/3c", a_out_data, a_out_tag, K128);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (a_blk_count !== 32'd1) begin n_fail++; $display("FAIL rel_count: got %0d want 1", a_blk_count); end
  endtask

  task automatic test_wrap;
    logic acc;
    for (int i = 0; i < 17; i++) cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 8'(i), 1'b1, acc);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, '0, 1'b1, acc);
    n_chk++;
    if (d_blk_count !== 4'd2) begin n_fail++; $display("FAIL wrap_cnt4: got %0d want 2", d_blk_count); end
    n_chk++;
    if (a_blk_count !== 32'd18 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL wrap_cnt32: got %0d left %0d want 18 0", a_blk_count, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sb[i] = sb_calc(8'(i));
    rk_a = expand(4);
    rk_b = expand(6);
    rk_c = expand(8);
    test_reset();
    test_kat();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_enc_pipe.md
# aes_enc_pipe

Parametrised, fully unrolled AES encryption pipeline supporting AES-128/192/256, with one round per stage, valid/ready flow control, tag passthrough and a completed-block counter. It supersedes the fixed AES-128 unrolled encryptor and sits between the round-key generator, which supplies the expanded key schedule, and the mode/stream logic that consumes ciphertext. It reuses the existing `add_round_key`, `encrypt_round` and `encrypt_final_round` combinational blocks.

## Interface
- KEY_BITS, 128, key length: 128, 192 or 256. Derived NR = 10, 12 or 14 rounds. Any other value fails elaboration.
- TAG_W, 8, width of the user tag carried alongside each block (≥1).
- CNT_W, 32, width of the completed-block counter.

- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- round_keys  in  (NR+1)*128  expanded schedule; bits [128*i+127:128*i] = round key i (i=0 is the whitening key)
- in_valid  in  1  input block valid
- in_ready  out  1  pipeline can accept this cycle
- in_data  in  128  plaintext block
- in_tag  in  TAG_W  user tag
- out_valid  out  1  ciphertext valid
- out_ready  in  1  consumer accepts
- out_data  out  128  ciphertext block
- out_tag  out  TAG_W  tag of the block on out_data
- busy  out  1  any stage holds a valid block
- blk_count  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W

## Operation
- NR register stages. Each stage holds a 128-bit state, a tag and a valid bit.
- Stage 1 input = encrypt_round(round key 1, in_data XOR round key 0). Stage s (2..NR-1) = encrypt_round(round key s, stage s-1). Stage NR = encrypt_final_round(round key NR, stage NR-1).
- Global advance enable: en = !(v[NR] && !out_ready). in_ready = en (combinational).
- When en=1, every stage loads from its predecessor. Stage 1 valid loads in_valid. Bubbles propagate as v=0.
- When en=0, all stages hold (data, tag, valid).
- out_valid = v[NR]; out_data / out_tag = stage NR registers.
- Output handshake = out_valid && out_ready. On a handshake, blk_count increments by 1 and wraps from all-ones to 0.
- busy = OR of all v[s].
- round_keys must remain stable while busy=1 or in_valid=1. Changing them mid-flight yields undefined ciphertext but never corrupts valid/tag/counter state.
- Reset (asynchronous assert, any time, including mid-stream): all v=0, all state and tag registers 0, blk_count=0. Blocks in flight are discarded.
- After deassertion: out_valid=0, out_data=0, out_tag=0, busy=0, blk_count=0. in_ready=1 on the first cycle.

## Timing
- Latency: a block accepted at edge E is presented with out_valid=1 after edge E+NR-1 (10/12/14 edges including E), provided no stall occurs.
- Each cycle with en=0 adds exactly one cycle of latency to every in-flight block.
- Throughput: 1 block/cycle while out_ready=1.
- in_ready depends combinationally on out_ready (no skid buffer). This is a documented path.
- Simultaneous input and output handshake on the same edge: both take effect, and the counter increments once.
- out_ready=0 with v[NR]=0: no stall. Bubbles in front of the output are still filled.
- out_data and out_tag are stable while out_valid=1 and out_ready=0.

## Test plan
- KEY_BITS=128, round_keys expanded from key 000102…0f, in_data 00112233445566778899aabbccddeeff, tag 0x5A, out_ready=1 → out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_tag 0x5A, exactly 10 edges after acceptance; blk_count=1.
- KEY_BITS=192 (key 000102…17) and KEY_BITS=256 (key 000102…1f), same plaintext → dda97ca4864cdfe06eaf70a0ec0d7191 after 12 edges; 8ea2b7ca516745bfeafc49904b496089 after 14 edges.
- 100 back-to-back random blocks with out_ready=1 → outputs match the reference model in order with incrementing tags, one per cycle, and blk_count=100.
- Random out_ready toggling with random in_valid gaps → no loss or duplication, order preserved, out_data stable during stalls, and in_ready=0 exactly when out_valid && !out_ready.
- Preload blk_count near wrap (CNT_W=4, 18 blocks) → value reads 2 after the last handshake.
- Assert rst_n low with 5 blocks in flight → out_valid, busy and blk_count go to 0 immediately without waiting for a clock edge. After release, none of the old blocks ever appears, and a new block completes after NR edges.
